// File: rtl/segasys1_snd_pkg.sv
// Shared definitions for the System 1 sound command path.
// Contents: NMI FSM state enum, default FIFO depth and NMI gap, command byte type.
package segasys1_snd_pkg;

  localparam int SNDCMD_DEPTH_LOG2 = 2;
  localparam int SNDCMD_NMI_GAP    = 16;

  typedef logic [7:0] snd_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    WAITPOP = 2'd2,
    GAP     = 2'd3
  } nmi_state_e;

endpackage

// File: rtl/segasys1_sndcmd_ram.sv
// Command byte storage for the sound command FIFO.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - byte to store
//   raddr  - asynchronous read address (FIFO read pointer)
//   rdata  - byte at raddr
module segasys1_sndcmd_ram
  import segasys1_snd_pkg::*;
#(
  parameter int ADDR_W = SNDCMD_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  snd_cmd_t          wdata,
  input  logic [ADDR_W-1:0] raddr,
  output snd_cmd_t          rdata
);

  snd_cmd_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/segasys1_sndcmd_fifo.sv
// Sound command FIFO between the main CPU sound request and the sound CPU.
// Captures each SNDRQ rising edge into a show-ahead FIFO, holds an NMI request
// to the sound CPU while commands are pending, and pops on the end of the
// sound CPU's command latch read.
// Optional build macro: SNDCMD_OVERWRITE_EN - a push into a full FIFO replaces
// the newest entry instead of being dropped (OVF is set either way).
// Ports:
//   CLK48M   - system clock
//   RESET_N  - asynchronous active-low reset
//   SNDRQ    - sound request from main CPU (level)
//   SNDNO    - command byte, valid while SNDRQ=1
//   SCPU_CS  - sound CPU command latch read strobe (level)
//   SNDDT    - command byte to sound CPU data selector
//   SNDNMI   - NMI request to sound CPU
//   EMPTY    - FIFO empty
//   FULL     - FIFO full
//   OVF      - sticky overflow flag
//
// NMI FSM:
//   state   | meaning
//   IDLE    | nothing signalled; move on when FIFO is non-empty
//   ASSERT  | SNDNMI high, waiting for the sound CPU to start its read
//   WAITPOP | read in progress, waiting for the strobe to end (the pop)
//   GAP     | enforced NMI low time before the next entry may be signalled
module segasys1_sndcmd_fifo
  import segasys1_snd_pkg::*;
#(
  parameter int DEPTH_LOG2 = SNDCMD_DEPTH_LOG2,
  parameter int NMI_GAP    = SNDCMD_NMI_GAP
) (
  input  logic     CLK48M,
  input  logic     RESET_N,
  input  logic     SNDRQ,
  input  snd_cmd_t SNDNO,
  input  logic     SCPU_CS,
  output snd_cmd_t SNDDT,
  output logic     SNDNMI,
  output logic     EMPTY,
  output logic     FULL,
  output logic     OVF
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
  localparam int GAP_W = (NMI_GAP > 2) ? $clog2(NMI_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(NMI_GAP - 1);

  logic rq_s, rq_d, cs_s, cs_d;
  logic rq_rise, cs_rise, cs_fall;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_addr;
  logic [DEPTH_LOG2:0]   count;
  logic do_pop, push_ok, push_full, wr_en;
  snd_cmd_t rd_data, last_q;
  nmi_state_e state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;

  // Inputs are registered once and then compared against their previous
  // sample, so a held SNDRQ/SCPU_CS level produces a single one-cycle event.
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      rq_s <= 1'b0;
      rq_d <= 1'b0;
      cs_s <= 1'b0;
      cs_d <= 1'b0;
    end else begin
      rq_s <= SNDRQ;
      rq_d <= rq_s;
      cs_s <= SCPU_CS;
      cs_d <= cs_s;
    end
  end

  assign rq_rise = rq_s & ~rq_d;
  assign cs_rise = cs_s & ~cs_d;
  assign cs_fall = ~cs_s & cs_d;

  assign EMPTY = (count == '0);
  assign FULL  = (count == DEPTH_CNT);

  assign do_pop = cs_fall & ~EMPTY;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok   = rq_rise & (~FULL | do_pop);
  assign push_full = rq_rise & FULL & ~do_pop;

`ifdef SNDCMD_OVERWRITE_EN
  assign wr_en   = push_ok | push_full;
  assign wr_addr = push_ok ? wr_ptr : (wr_ptr - 1'b1);
`else
  assign wr_en   = push_ok;
  assign wr_addr = wr_ptr;
`endif

  segasys1_sndcmd_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (CLK48M),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (SNDNO),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
      OVF    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= rd_data;
      end
      if (push_ok && !do_pop)      count <= count + 1'b1;
      else if (!push_ok && do_pop) count <= count - 1'b1;
      if (push_full) OVF <= 1'b1;
    end
  end

  // Show-ahead while entries remain; after the last pop the sound CPU keeps
  // seeing the byte it just read.
  assign SNDDT = EMPTY ? last_q : rd_data;

  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    SNDNMI    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!EMPTY) state_nxt = ASSERT;
      end
      ASSERT: begin
        SNDNMI = 1'b1;
        if (cs_rise) state_nxt = WAITPOP;
      end
      WAITPOP: begin
        if (cs_fall) begin
          gap_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
